// File: rtl/mask_encoder_if.sv
// Handshake bundle for mask_encoder: mask input channel, index output channel and status.
interface mask_encoder_if #(
    parameter int IDX_W = 3,
    parameter int WIDTH = 2 ** IDX_W
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_mask;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_idx;
    logic [WIDTH-1:0]   out_onehot;
    logic               out_last;
    logic [IDX_W:0]     pending_cnt;

    modport master (
        output in_valid, in_mask, out_ready,
        input  in_ready, out_valid, out_idx, out_onehot, out_last, pending_cnt
    );

    modport slave (
        input  in_valid, in_mask, out_ready,
        output in_ready, out_valid, out_idx, out_onehot, out_last, pending_cnt
    );
endinterface

// File: rtl/mask_encoder.sv
// Sequential mask-to-index encoder: emits the index of each set bit of an accepted
// mask, lowest first, one per output handshake.
module mask_encoder #(
    parameter int IDX_W = 3,
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mask_encoder_if.slave bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   pending, pending_nxt;
    logic [WIDTH-1:0]   onehot;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W:0]     cnt;
    logic               last;
    logic               in_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    // All outputs derive from registered state only; rst merely masks in_ready.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (pending[i]) idx = IDX_W'(i);
        cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            cnt = cnt + (IDX_W + 1)'(pending[i]);
    end

    assign onehot     = pending & (~pending + WIDTH'(1));
    assign last       = (state == EMIT) && (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
    assign in_ready_i = (state == IDLE) && !rst;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                // A zero mask is consumed without producing any output.
                if (bus.in_valid && in_ready_i && (bus.in_mask != '0)) begin
                    pending_nxt = bus.in_mask;
                    state_nxt   = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    pending_nxt = pending & ~onehot;
                    if (last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready    = in_ready_i;
    assign bus.out_valid   = (state == EMIT);
    assign bus.out_idx     = idx;
    assign bus.out_onehot  = onehot;
    assign bus.out_last    = last;
    assign bus.pending_cnt = cnt;
endmodule

// File: tb/tb_mask_encoder.sv
// Scoreboard bench for mask_encoder: the monitor builds expected index lists from each
// accepted mask and checks every output cycle against the head of the queue.
module tb_mask_encoder;
    typedef struct {
        logic [2:0] idx;
        logic [7:0] oh;
        logic       last;
        logic [3:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   pops = 0;
    int   mode = 0;     // 0: out_ready high, 1: toggling, 2: random
    bit   busy = 0;
    exp_t q[$];

    mask_encoder_if #(.IDX_W(3), .WIDTH(8)) bus ();

    mask_encoder #(.IDX_W(3), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list the set-bit positions of the mask in ascending order.
    task automatic model_push(input logic [7:0] m);
        int n = $countones(m);
        int k = 0;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                e.idx  = 3'(i);
                e.oh   = 8'(1) << i;
                e.last = (k == n - 1);
                e.cnt  = 4'(n - k);
                q.push_back(e);
                k++;
            end
        end
    endtask

    // Monitor: check outputs mid-cycle, then advance the model across the coming edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("in_ready_rst", 32'(bus.in_ready), 0);
                chk("out_valid_rst", 32'(bus.out_valid), 32'(busy));
                q.delete();
                busy = 0;
            end else begin
                chk("in_ready", 32'(bus.in_ready), 32'(!busy));
                chk("out_valid", 32'(bus.out_valid), 32'(busy));
                if (!busy) begin
                    chk("idle_cnt", 32'(bus.pending_cnt), 0);
                    chk("idle_last", 32'(bus.out_last), 0);
                    chk("idle_onehot", 32'(bus.out_onehot), 0);
                    if (bus.in_valid && bus.in_mask != 8'h00) begin
                        model_push(bus.in_mask);
                        busy = 1;
                    end
                end else if (q.size() == 0) begin
                    chk("queue_nonempty", 0, 1);
                    busy = 0;
                end else begin
                    e = q[0];
                    chk("out_idx", 32'(bus.out_idx), 32'(e.idx));
                    chk("out_onehot", 32'(bus.out_onehot), 32'(e.oh));
                    chk("out_last", 32'(bus.out_last), 32'(e.last));
                    chk("pending_cnt", 32'(bus.pending_cnt), 32'(e.cnt));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        pops++;
                        if (e.last) busy = 0;
                    end
                end
            end
        end
    end

    // out_ready driver, updated just after each rising edge.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom);
            endcase
        end
    end

    task automatic send(input logic [7:0] m);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_mask  = m;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready && !rst) ok = 1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (!busy && q.size() == 0) ok = 1;
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int target;
        bus.in_valid = 1'b1;
        bus.in_mask  = 8'hA5;
        // Reset held with a mask offered: nothing may be accepted.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        mode = 0;
        send(8'hA6);
        drain();

        mode = 1;
        send(8'hFF);
        drain();

        mode = 0;
        send(8'h00);
        send(8'h80);
        drain();

        send(8'h01);
        send(8'h10);
        drain();

        // Reset after two handshakes of 3C: indices 4 and 5 must never appear.
        target = pops + 2;
        send(8'h3C);
        for (int n = 0; n < 50 && pops < target; n++) @(negedge clk);
        if (pops < target) chk("rst_mid_timeout", 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(bus.out_valid), 0);
        chk("rst_mid_cnt", 32'(bus.pending_cnt), 0);
        @(posedge clk);
        #1;

        mode = 2;
        for (int t = 0; t < 150; t++) begin
            logic [7:0] m;
            case ($urandom_range(0, 7))
                0: m = 8'h00;
                1: m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            send(m);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
